// File: rtl/array_feeder_if.sv
// Handshake and array-edge bus between the upstream vector source and the systolic feeder.
// Lanes are packed with lane i at bits [i*BITWIDTH +: BITWIDTH].
interface array_feeder_if #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned N        = 4
);
  logic                  start;
  logic [7:0]            k_len;
  logic                  in_valid;
  logic                  in_ready;
  logic [N*BITWIDTH-1:0] in_data_vec;
  logic [N*BITWIDTH-1:0] in_weight_vec;
  logic [N*BITWIDTH-1:0] top_data;
  logic [N*BITWIDTH-1:0] left_weight;
  logic                  compute_en;
  logic                  load_weights;
  logic                  busy;
  logic                  done;

  modport master (
    output start, k_len, in_valid, in_data_vec, in_weight_vec,
    input  in_ready, top_data, left_weight, compute_en, load_weights, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, in_data_vec, in_weight_vec,
    output in_ready, top_data, left_weight, compute_en, load_weights, busy, done
  );
endinterface

// File: rtl/array_feeder.sv
// Skews data/weight vectors onto the top and left edges of an NxN systolic array and
// sequences one matrix-multiply pass: clear, feed k_len vectors, drain 2N-2 cycles, done.
module array_feeder #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned N        = 4
) (
  input logic           clk,
  input logic           reset,
  array_feeder_if.slave bus
);
  localparam int unsigned          DrainW    = $clog2(2 * N - 2);
  localparam logic [DrainW-1:0]    DrainLast = DrainW'(2 * N - 3);

  typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [7:0]         k_len_q, k_len_d;
  logic [7:0]         beat_q, beat_d;
  logic [DrainW-1:0]  drain_q, drain_d;
  logic               compute_en_q;
  logic               done_q, done_d;
  logic               advance;
  logic               clear;
  logic               feed_sel;

  logic [N-1:0][BITWIDTH-1:0] top_lanes;
  logic [N-1:0][BITWIDTH-1:0] left_lanes;

  always_comb begin
    state_d  = state_q;
    k_len_d  = k_len_q;
    beat_d   = beat_q;
    drain_d  = drain_q;
    advance  = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && (bus.k_len != 8'd0)) begin
          state_d = StClear;
          k_len_d = bus.k_len;
        end
      end
      StClear: begin
        clear   = 1'b1;
        beat_d  = '0;
        drain_d = '0;
        state_d = StFeed;
      end
      StFeed: begin
        if (bus.in_valid) begin
          advance = 1'b1;
          beat_d  = beat_q + 8'd1;
          if (beat_d == k_len_q) state_d = StDrain;
        end
      end
      StDrain: begin
        advance = 1'b1;
        drain_d = drain_q + DrainW'(1);
        if (drain_q == DrainLast) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // done trails the DONE state so it lands the cycle after the last compute_en.
  assign done_d   = (state_q == StDone);
  assign feed_sel = (state_q == StFeed);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      k_len_q      <= '0;
      beat_q       <= '0;
      drain_q      <= '0;
      compute_en_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_len_q      <= k_len_d;
      beat_q       <= beat_d;
      drain_q      <= drain_d;
      compute_en_q <= advance;
      done_q       <= done_d;
    end
  end

  // Lane i is a chain of i+1 registers; its tail drives column/row i of the array.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [i:0][BITWIDTH-1:0] data_q, data_d;
    logic [i:0][BITWIDTH-1:0] wt_q, wt_d;

    always_comb begin
      data_d = data_q;
      wt_d   = wt_q;
      if (clear) begin
        data_d = '0;
        wt_d   = '0;
      end else if (advance) begin
        data_d[0] = feed_sel ? bus.in_data_vec[i*BITWIDTH +: BITWIDTH] : '0;
        wt_d[0]   = feed_sel ? bus.in_weight_vec[i*BITWIDTH +: BITWIDTH] : '0;
        for (int j = 1; j <= i; j++) begin
          data_d[j] = data_q[j-1];
          wt_d[j]   = wt_q[j-1];
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_q <= '0;
        wt_q   <= '0;
      end else begin
        data_q <= data_d;
        wt_q   <= wt_d;
      end
    end

    assign top_lanes[i]  = data_q[i];
    assign left_lanes[i] = wt_q[i];
  end

  assign bus.top_data     = top_lanes;
  assign bus.left_weight  = left_lanes;
  assign bus.in_ready     = feed_sel;
  assign bus.load_weights = (state_q == StClear);
  assign bus.busy         = (state_q != StIdle);
  assign bus.compute_en   = compute_en_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_array_feeder.sv
// Randomized pass-level bench for array_feeder; a history of accepted vectors predicts the
// skewed edge values, compute_en cadence, handshake flags and done timing.
module tb_array_feeder;
  localparam int unsigned BW = 8;
  localparam int unsigned NL = 4;
  localparam int unsigned VW = NL * BW;

  logic clk = 1'b0;
  logic reset = 1'b1;

  array_feeder_if #(.BITWIDTH(BW), .N(NL)) bus ();
  array_feeder #(.BITWIDTH(BW), .N(NL)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Every vector that entered the skew chains since the last clear (drain zeros included).
  logic [VW-1:0] hist_d[$];
  logic [VW-1:0] hist_w[$];
  bit            ce_prev;
  int            ce_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lane i shows the element entered i advances before the newest one, zero if none yet.
  function automatic logic [VW-1:0] skew_exp(input bit weight);
    logic [VW-1:0] v;
    logic [VW-1:0] e;
    int sz;
    v  = '0;
    sz = hist_d.size();
    for (int i = 0; i < NL; i++) begin
      if (sz > i) begin
        e = weight ? hist_w[sz-1-i] : hist_d[sz-1-i];
        v[i*BW +: BW] = e[i*BW +: BW];
      end
    end
    return v;
  endfunction

  task automatic check_cycle(input string ph, input bit exp_rdy);
    check_eq({ph, "_ce"},   bus.compute_en, ce_prev);
    check_eq({ph, "_top"},  bus.top_data, skew_exp(1'b0));
    check_eq({ph, "_left"}, bus.left_weight, skew_exp(1'b1));
    check_eq({ph, "_rdy"},  bus.in_ready, exp_rdy);
    check_eq({ph, "_lw"},   bus.load_weights, 0);
    check_eq({ph, "_busy"}, bus.busy, 1);
    check_eq({ph, "_done"}, bus.done, 0);
    if (bus.compute_en) ce_cnt++;
  endtask

  task automatic do_pass(input int k, input int vpct, input bit directed, input bit poke_start);
    logic [VW-1:0] dv, wv;
    int beats = 0;
    int guard = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = 8'(k);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.k_len = 8'($urandom);
    check_eq("clr_lw",   bus.load_weights, 1);
    check_eq("clr_busy", bus.busy, 1);
    check_eq("clr_rdy",  bus.in_ready, 0);
    check_eq("clr_ce",   bus.compute_en, 0);
    hist_d.delete();
    hist_w.delete();
    ce_prev = 1'b0;
    ce_cnt  = 0;
    while (beats < k) begin
      @(negedge clk);
      check_cycle("feed", 1'b1);
      guard++;
      if (guard > 4000) begin
        check_eq("feed_timeout", 0, 1);
        break;
      end
      dv = $urandom;
      wv = $urandom;
      if (directed) begin
        for (int i = 0; i < NL; i++) begin
          dv[i*BW +: BW] = 8'(10 * beats + i);
          wv[i*BW +: BW] = 8'(100 + 10 * beats + i);
        end
      end
      bus.in_valid      = ($urandom_range(99) < 32'(vpct));
      bus.in_data_vec   = dv;
      bus.in_weight_vec = wv;
      ce_prev = bus.in_valid;
      if (bus.in_valid) begin
        hist_d.push_back(dv);
        hist_w.push_back(wv);
        beats++;
      end
    end
    for (int c = 0; c < 2 * NL - 2; c++) begin
      @(negedge clk);
      check_cycle("drain", 1'b0);
      bus.in_valid      = 1'($urandom_range(1));
      bus.in_data_vec   = $urandom;
      bus.in_weight_vec = $urandom;
      bus.start         = poke_start && (c == 0);
      bus.k_len         = 8'd5;
      ce_prev = 1'b1;
      hist_d.push_back('0);
      hist_w.push_back('0);
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check_cycle("donest", 1'b0);
    @(negedge clk);
    check_eq("fin_done", bus.done, 1);
    check_eq("fin_busy", bus.busy, 0);
    check_eq("fin_ce",   bus.compute_en, 0);
    check_eq("fin_lw",   bus.load_weights, 0);
    check_eq("ce_total", 64'(ce_cnt), 64'(k + 2 * NL - 2));
    @(negedge clk);
    check_eq("post_done", bus.done, 0);
    check_eq("post_busy", bus.busy, 0);
  endtask

  task automatic check_all_zero(input string ph);
    check_eq({ph, "_top"},  bus.top_data, 0);
    check_eq({ph, "_left"}, bus.left_weight, 0);
    check_eq({ph, "_ce"},   bus.compute_en, 0);
    check_eq({ph, "_lw"},   bus.load_weights, 0);
    check_eq({ph, "_busy"}, bus.busy, 0);
    check_eq({ph, "_done"}, bus.done, 0);
    check_eq({ph, "_rdy"},  bus.in_ready, 0);
  endtask

  initial begin
    bus.start         = 1'b0;
    bus.k_len         = '0;
    bus.in_valid      = 1'b0;
    bus.in_data_vec   = '0;
    bus.in_weight_vec = '0;
    #1;
    check_all_zero("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // start with k_len=0 is ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = 8'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("k0_busy", bus.busy, 0);
    check_eq("k0_lw",   bus.load_weights, 0);
    @(negedge clk);
    check_eq("k0_busy2", bus.busy, 0);

    do_pass(3, 100, 1'b1, 1'b0);
    do_pass(4, 100, 1'b1, 1'b1);
    do_pass(1, 100, 1'b0, 1'b0);
    do_pass(6, 50, 1'b1, 1'b0);
    for (int p = 0; p < 8; p++) begin
      do_pass(int'($urandom_range(12, 1)), int'($urandom_range(100, 30)), 1'b0, p[0]);
    end

    // Reset in FEED after two accepts abandons the pass.
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = 8'd6;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data_vec   = $urandom;
    bus.in_weight_vec = $urandom;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check_eq("after_rst_done", bus.done, 0);
      check_eq("after_rst_busy", bus.busy, 0);
    end
    do_pass(2, 100, 1'b0, 1'b0);
    do_pass(int'($urandom_range(20, 8)), 70, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
